// File: rtl/im_port_arbiter.sv
// im_port_arbiter: two-master arbiter/sequencer in front of the instruction memory.
// Master 0 is the instruction-fetch port (read only), master 1 is the loader/debug
// port (read/write). One access is in flight at a time; each access goes
// IDLE -> ACCESS -> RESP. An access with a bad address goes IDLE -> RESP.
module im_port_arbiter #(
  parameter logic [31:0] ADDR_START  = 32'h0000_3000,
  parameter int unsigned WORD_NUM    = 4096,
  parameter int unsigned TIMEOUT     = 16,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  // master 0: instruction fetch
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  // master 1: loader / debug
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  // memory side
  output logic        s_ce,
  output logic        s_we,
  output logic        s_re,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_din,
  input  logic [31:0] s_dout,
  input  logic        s_ready
);

  // The timeout counter only has to reach TIMEOUT-1.
  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  // End of the memory window, one bit wider so ADDR_START + 4*WORD_NUM cannot wrap.
  localparam logic [32:0]      ADDR_END = {1'b0, ADDR_START} + (33'(WORD_NUM) << 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t           state_q;
  logic             ptr_q;      // master that wins a tie (round-robin only)
  logic             id_q;       // master currently being served
  logic             we_q;       // latched write flag of the current access
  logic [CNT_W-1:0] cnt_q;      // cycles spent in ACCESS without ready

  // registered master-side responses, indexed by master id
  logic [1:0]       ack_q;
  logic [1:0]       err_q;
  logic [31:0]      rdata_q [2];

  // registered memory-side strobes, only non-zero while in ACCESS
  logic             s_ce_q;
  logic             s_we_q;
  logic             s_re_q;
  logic [3:0]       s_be_q;
  logic [31:0]      s_addr_q;
  logic [31:0]      s_din_q;

  // grant decision and the request fields of the winner
  logic             gnt_id_d;
  logic [31:0]      sel_addr_d;
  logic             sel_we_d;
  logic [3:0]       sel_be_d;
  logic [31:0]      sel_wdata_d;
  logic             addr_ok_d;
  logic [31:0]      word_idx_d;

  // Pick the winner and check its address against the memory window.
  always_comb begin
    gnt_id_d    = 1'b0;
    sel_addr_d  = m0_addr;
    sel_we_d    = 1'b0;
    sel_be_d    = 4'hF;
    sel_wdata_d = 32'h0;
    addr_ok_d   = 1'b0;
    word_idx_d  = 32'h0;

    if (m0_req && m1_req) begin
      gnt_id_d = ROUND_ROBIN ? ptr_q : 1'b0;
    end else begin
      gnt_id_d = m1_req;
    end

    // fetch port is always a full-word read
    if (gnt_id_d) begin
      sel_addr_d  = m1_addr;
      sel_we_d    = m1_we;
      sel_be_d    = m1_be;
      sel_wdata_d = m1_wdata;
    end

    addr_ok_d  = (sel_addr_d[1:0] == 2'b00) &&
                 (sel_addr_d >= ADDR_START) &&
                 ({1'b0, sel_addr_d} < ADDR_END);
    word_idx_d = (sel_addr_d - ADDR_START) >> 2;
  end

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      rdata_q[0] <= 32'h0;
      rdata_q[1] <= 32'h0;
      s_ce_q     <= 1'b0;
      s_we_q     <= 1'b0;
      s_re_q     <= 1'b0;
      s_be_q     <= 4'h0;
      s_addr_q   <= 32'h0;
      s_din_q    <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            id_q <= gnt_id_d;
            we_q <= sel_we_d;
            if (!addr_ok_d) begin
              // bad address: answer with an error, never touch the memory
              state_q           <= ST_RESP;
              ack_q[gnt_id_d]   <= 1'b1;
              err_q[gnt_id_d]   <= 1'b1;
              rdata_q[gnt_id_d] <= 32'h0;
            end else begin
              state_q  <= ST_ACCESS;
              cnt_q    <= '0;
              s_ce_q   <= 1'b1;
              s_we_q   <= sel_we_d;
              s_re_q   <= !sel_we_d;
              s_be_q   <= sel_we_d ? sel_be_d : 4'h0;
              s_addr_q <= word_idx_d;
              s_din_q  <= sel_wdata_d;
            end
          end
        end

        ST_ACCESS: begin
          if (s_ready || (cnt_q == CNT_LAST)) begin
            // a ready on the last allowed cycle still counts as success
            state_q       <= ST_RESP;
            ack_q[id_q]   <= 1'b1;
            err_q[id_q]   <= !s_ready;
            rdata_q[id_q] <= (s_ready && !we_q) ? s_dout : 32'h0;
            s_ce_q        <= 1'b0;
            s_we_q        <= 1'b0;
            s_re_q        <= 1'b0;
            s_be_q        <= 4'h0;
            s_addr_q      <= 32'h0;
            s_din_q       <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RESP: begin
          // ack/err are single-cycle pulses; rdata keeps its value
          ack_q   <= 2'b00;
          err_q   <= 2'b00;
          state_q <= ST_IDLE;
          if (ROUND_ROBIN) begin
            ptr_q <= !id_q;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_ack   = ack_q[0];
  assign m0_err   = err_q[0];
  assign m0_rdata = rdata_q[0];
  assign m1_ack   = ack_q[1];
  assign m1_err   = err_q[1];
  assign m1_rdata = rdata_q[1];

  assign s_ce     = s_ce_q;
  assign s_we     = s_we_q;
  assign s_re     = s_re_q;
  assign s_be     = s_be_q;
  assign s_addr   = s_addr_q;
  assign s_din    = s_din_q;

endmodule

// File: doc/im_port_arbiter.md
Name: im_port_arbiter

Overview:
- Two-master, one-slave arbiter/sequencer in front of the instruction memory.
- Master 0 is the pipeline instruction-fetch port; master 1 is the program-loader/debug port (read/write).
- Sequences each access through the memory's ce/we/re/be/ready interface.
- Translates byte addresses to word indices, checks range and alignment, and converts a non-responding memory into an error response.

Parameters:
ADDR_START, 32'h0000_3000, byte address of memory word 0
WORD_NUM, 4096, number of 32-bit words in the memory
TIMEOUT, 16, max cycles ACCESS waits for s_ready before error (>=1)
ROUND_ROBIN, 1, 1 = alternate priority after each grant; 0 = master 0 always wins

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 request; held with m0_addr stable until m0_ack
m0_addr  input  32  master 0 byte address
m0_ack  output  1  one-cycle completion pulse to master 0
m0_err  output  1  valid with m0_ack: range/alignment/timeout error
m0_rdata  output  32  read data, valid with m0_ack
m1_req  input  1  master 1 request; held with fields stable until m1_ack
m1_addr  input  32  master 1 byte address
m1_we  input  1  master 1 write (1) / read (0)
m1_be  input  4  master 1 byte enables for writes
m1_wdata  input  32  master 1 write data
m1_ack  output  1  one-cycle completion pulse to master 1
m1_err  output  1  valid with m1_ack
m1_rdata  output  32  read data, valid with m1_ack
s_ce  output  1  memory chip enable
s_we  output  1  memory write enable
s_re  output  1  memory read enable
s_be  output  4  memory byte enables
s_addr  output  32  memory word index = (byte_addr - ADDR_START) >> 2
s_din  output  32  memory write data
s_dout  input  32  memory read data
s_ready  input  1  memory access complete (may be constant 1)

Behaviour:
- Reset, asynchronous:
  - State = IDLE, priority pointer = master 0, timeout counter = 0.
  - All outputs 0, including m*_ack, m*_err, m*_rdata and all s_*.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Samples m0_req/m1_req.
  - One requester: grant it.
  - Both requesting: grant the pointer's master (ROUND_ROBIN=1) or master 0 (ROUND_ROBIN=0).
  - On grant, latch master id, addr, we, be and wdata; master 0 always uses we=0, be=4'hF.
  - Illegal latched address (addr[1:0]!=0, addr<ADDR_START, or addr>=ADDR_START+4*WORD_NUM, computed without 32-bit overflow): go to RESP with err=1; no memory access.
  - Otherwise go to ACCESS and clear the counter.
- ACCESS:
  - s_ce=1, s_re=!we, s_we=we, s_be=be when writing else 4'h0, s_addr=word index, s_din=wdata.
  - If s_ready: capture s_dout (reads; writes capture 0) and go to RESP with err=0.
  - Else increment the counter; when it reaches TIMEOUT-1 without ready, go to RESP with err=1, rdata=0.
  - All s_* are 0 outside ACCESS.
- RESP:
  - Registered m<id>_ack=1 for exactly one cycle, with m<id>_err and m<id>_rdata. The other master's ack stays 0.
  - Toggle the pointer away from the served master (ROUND_ROBIN=1). Next state IDLE.
- m*_rdata holds its value until that master's next ack; m*_err is meaningful only with ack.
- Latency with s_ready=1: request seen in IDLE at cycle T, ACCESS at T+1, ack at T+2. Minimum 3 cycles per access; a new grant is possible at T+3.
- Requests dropped before ack are protocol violations. The arbiter still completes the latched access and pulses ack.
- Reset asserted mid-ACCESS aborts immediately: no ack, no further s_we.
- At most one access is outstanding; no requests are queued.

Test Plan:
- Reset with both reqs high -> all outputs 0; after release, m0 granted first; s_addr for m0_addr=32'h0000_3004 is 1; m0_ack at T+2 with m0_rdata = memory word 1.
- Both requesting continuously, ROUND_ROBIN=1, s_ready=1 -> acks alternate m0, m1, m0, m1, each 3 cycles apart; with ROUND_ROBIN=0 only m0 is served while it requests.
- m1 write addr=32'h0000_3008, be=4'b0011, wdata=32'hDEAD_BEEF -> one ACCESS cycle with s_we=1, s_re=0, s_addr=2, s_be=4'b0011; read-back returns the merged word; m1_err=0.
- m0_addr=32'h0000_2FFC, 32'h0000_3002 and ADDR_START+4*WORD_NUM -> m0_ack with m0_err=1, m0_rdata=0, s_ce never asserted.
- s_ready held 0, TIMEOUT=16 -> s_ce high for exactly 16 cycles, then ack with err=1, rdata=0; with ready arriving on the 5th ACCESS cycle -> ack with err=0 and captured data.
- Reset pulsed during ACCESS of an m1 write -> s_* drop to 0 asynchronously, no m1_ack; after release, a re-issued request completes normally.
